// File: rtl/uart_prog_loader_pkg.sv
// Shared types and constants for the UART program loader.
package uart_prog_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN0  = 3'd1,
    ST_LEN1  = 3'd2,
    ST_DATA  = 3'd3,
    ST_CSUM  = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERROR = 3'd6
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CSUM    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic [7:0] MAGIC = 8'hA5;

endpackage

// File: rtl/prog_loader_gap_timer.sv
// Idle-cycle counter between received bytes; flags the cycle on which the
// GAP_TIMEOUT-th consecutive idle clock is reached.
module prog_loader_gap_timer #(
  parameter int GAP_TIMEOUT = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expired
);

  localparam int CNT_W = $clog2(GAP_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(GAP_TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  // Count idle clocks while enabled; any byte or disable restarts from zero.
  always_ff @(posedge clk) begin
    if (rst || clr || !en) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = en && !clr && (count == LAST);

endmodule

// File: rtl/uart_prog_loader.sv
// Framed UART program loader: header/length check, little-endian word
// assembly into instruction memory, checksum verification and gap timeout.
module uart_prog_loader
  import uart_prog_loader_pkg::*;
#(
  parameter int WORD_W      = 32,
  parameter int ADDR_W      = 8,
  parameter int MAX_WORDS   = 256,
  parameter int GAP_TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_dv_i,
  input  logic [7:0]        rx_byte_i,
  input  logic              restart_i,
  output logic              we_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [WORD_W-1:0] wdata_o,
  output logic              active_o,
  output logic              err_o,
  output logic [1:0]        err_code_o,
  output logic [15:0]       words_o
);

  localparam int BYTES  = WORD_W / 8;
  localparam int BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(BYTES - 1);
  localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

  state_t              state, state_n;
  logic [15:0]         len, len_n;
  logic [BIDX_W-1:0]   bidx, bidx_n;
  logic [7:0]          sum, sum_n;
  logic [WORD_W-1:0]   acc, acc_n;
  logic [WORD_W-1:0]   assembled;
  logic [15:0]         n_len;
  logic                we_n, active_n, err_n;
  logic [ADDR_W-1:0]   addr_n;
  logic [WORD_W-1:0]   wdata_n;
  logic [1:0]          code_n;
  logic [15:0]         words_n;
  logic                in_frame, expired;

  assign in_frame = (state == ST_LEN0) || (state == ST_LEN1) ||
                    (state == ST_DATA) || (state == ST_CSUM);

  prog_loader_gap_timer #(.GAP_TIMEOUT(GAP_TIMEOUT)) u_gap (
    .clk     (clk),
    .rst     (rst),
    .en      (in_frame),
    .clr     (rx_dv_i | restart_i),
    .expired (expired)
  );

  // Drop the incoming byte into its lane of the partially built word.
  always_comb begin
    assembled = acc;
    for (int k = 0; k < BYTES; k++) begin
      if (bidx == BIDX_W'(k)) begin
        assembled[8*k +: 8] = rx_byte_i;
      end else begin
        assembled[8*k +: 8] = acc[8*k +: 8];
      end
    end
  end

  // Next-state and output logic; priority restart > timeout > byte.
  always_comb begin
    state_n  = state;
    len_n    = len;
    bidx_n   = bidx;
    sum_n    = sum;
    acc_n    = acc;
    we_n     = 1'b0;
    addr_n   = addr_o;
    wdata_n  = wdata_o;
    active_n = active_o;
    err_n    = err_o;
    code_n   = err_code_o;
    words_n  = words_o;
    n_len    = {rx_byte_i, len[7:0]};
    if (restart_i) begin
      state_n  = ST_IDLE;
      active_n = 1'b0;
      err_n    = 1'b0;
      code_n   = ERR_NONE;
    end else if (expired) begin
      state_n  = ST_ERROR;
      active_n = 1'b0;
      err_n    = 1'b1;
      code_n   = ERR_TIMEOUT;
    end else if (rx_dv_i) begin
      case (state)
        ST_IDLE: begin
          if (rx_byte_i == MAGIC) begin
            state_n = ST_LEN0;
            words_n = 16'd0;
            bidx_n  = '0;
            sum_n   = 8'd0;
            acc_n   = '0;
            err_n   = 1'b0;
            code_n  = ERR_NONE;
          end else begin
            state_n = ST_IDLE;
          end
        end
        ST_LEN0: begin
          len_n   = {8'h00, rx_byte_i};
          state_n = ST_LEN1;
        end
        ST_LEN1: begin
          len_n = n_len;
          if ((n_len == 16'd0) || (n_len > MAX_N)) begin
            state_n  = ST_ERROR;
            active_n = 1'b0;
            err_n    = 1'b1;
            code_n   = ERR_LEN;
          end else begin
            state_n = ST_DATA;
          end
        end
        ST_DATA: begin
          sum_n = sum + rx_byte_i;
          if (bidx == LAST_BYTE) begin
            we_n    = 1'b1;
            addr_n  = ADDR_W'(words_o);
            wdata_n = assembled;
            words_n = words_o + 16'd1;
            bidx_n  = '0;
            acc_n   = '0;
            if (words_o == (len - 16'd1)) begin
              state_n = ST_CSUM;
            end else begin
              state_n = ST_DATA;
            end
          end else begin
            acc_n  = assembled;
            bidx_n = bidx + BIDX_W'(1);
          end
        end
        ST_CSUM: begin
          if (rx_byte_i == sum) begin
            state_n  = ST_DONE;
            active_n = 1'b1;
          end else begin
            state_n  = ST_ERROR;
            active_n = 1'b0;
            err_n    = 1'b1;
            code_n   = ERR_CSUM;
          end
        end
        ST_DONE:  state_n = ST_DONE;
        ST_ERROR: state_n = ST_ERROR;
        default:  state_n = ST_IDLE;
      endcase
    end else begin
      state_n = state;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      len        <= 16'd0;
      bidx       <= '0;
      sum        <= 8'd0;
      acc        <= '0;
      we_o       <= 1'b0;
      addr_o     <= '0;
      wdata_o    <= '0;
      active_o   <= 1'b0;
      err_o      <= 1'b0;
      err_code_o <= ERR_NONE;
      words_o    <= 16'd0;
    end else begin
      state      <= state_n;
      len        <= len_n;
      bidx       <= bidx_n;
      sum        <= sum_n;
      acc        <= acc_n;
      we_o       <= we_n;
      addr_o     <= addr_n;
      wdata_o    <= wdata_n;
      active_o   <= active_n;
      err_o      <= err_n;
      err_code_o <= code_n;
      words_o    <= words_n;
    end
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Scoreboard bench: a 32-bit and a 16-bit loader instance driven by directed
// frames; memory writes are checked by a monitor against queued expectations.
module tb_uart_prog_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        dv_a, restart_a, we_a, active_a, err_a;
  logic [7:0]  byte_a, addr_a;
  logic [31:0] wdata_a;
  logic [1:0]  code_a;
  logic [15:0] words_a;

  logic        dv_b, restart_b, we_b, active_b, err_b;
  logic [7:0]  byte_b;
  logic [3:0]  addr_b;
  logic [15:0] wdata_b;
  logic [1:0]  code_b;
  logic [15:0] words_b;

  int checks = 0;
  int errors = 0;
  logic [39:0] exp_a[$];
  logic [19:0] exp_b[$];
  logic [7:0]  fr[$];

  uart_prog_loader #(.WORD_W(32), .ADDR_W(8), .MAX_WORDS(256), .GAP_TIMEOUT(16)) dut_a (
    .clk(clk), .rst(rst), .rx_dv_i(dv_a), .rx_byte_i(byte_a), .restart_i(restart_a),
    .we_o(we_a), .addr_o(addr_a), .wdata_o(wdata_a), .active_o(active_a),
    .err_o(err_a), .err_code_o(code_a), .words_o(words_a)
  );

  uart_prog_loader #(.WORD_W(16), .ADDR_W(4), .MAX_WORDS(16), .GAP_TIMEOUT(16)) dut_b (
    .clk(clk), .rst(rst), .rx_dv_i(dv_b), .rx_byte_i(byte_b), .restart_i(restart_b),
    .we_o(we_b), .addr_o(addr_b), .wdata_o(wdata_b), .active_o(active_b),
    .err_o(err_b), .err_code_o(code_b), .words_o(words_b)
  );

  // Write monitor: every we_o pulse must match the head of its queue.
  always @(negedge clk) begin
    if (we_a === 1'b1) begin
      checks++;
      if (exp_a.size() == 0) begin
        errors++;
        $display("FAIL wr_a unexpected addr=%0h data=%0h", addr_a, wdata_a);
      end else begin
        logic [39:0] e;
        e = exp_a.pop_front();
        if ({addr_a, wdata_a} !== e) begin
          errors++;
          $display("FAIL wr_a actual=%0h expected=%0h", {addr_a, wdata_a}, e);
        end
      end
    end
    if (we_b === 1'b1) begin
      checks++;
      if (exp_b.size() == 0) begin
        errors++;
        $display("FAIL wr_b unexpected addr=%0h data=%0h", addr_b, wdata_b);
      end else begin
        logic [19:0] e;
        e = exp_b.pop_front();
        if ({addr_b, wdata_b} !== e) begin
          errors++;
          $display("FAIL wr_b actual=%0h expected=%0h", {addr_b, wdata_b}, e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_a(input logic [7:0] b);
    dv_a = 1'b1; byte_a = b;
    @(posedge clk); #1;
    dv_a = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] b);
    dv_b = 1'b1; byte_b = b;
    @(posedge clk); #1;
    dv_b = 1'b0;
  endtask

  task automatic send_frame_a();
    foreach (fr[i]) send_a(fr[i]);
  endtask

  task automatic send_frame_b();
    foreach (fr[i]) send_b(fr[i]);
  endtask

  task automatic restart_pulse_a();
    restart_a = 1'b1;
    @(posedge clk); #1;
    restart_a = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    dv_a = 1'b0; byte_a = 8'h00; restart_a = 1'b0;
    dv_b = 1'b0; byte_b = 8'h00; restart_b = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(1);
    check("rst_we_a", {31'd0, we_a}, 32'd0);
    check("rst_addr_a", {24'd0, addr_a}, 32'd0);
    check("rst_wdata_a", wdata_a, 32'd0);
    check("rst_active_a", {31'd0, active_a}, 32'd0);
    check("rst_err_a", {29'd0, err_a, code_a}, 32'd0);
    check("rst_words_a", {16'd0, words_a}, 32'd0);

    // Two-word frame with the correct checksum (sum of payload = 0x44C).
    exp_a.push_back({8'h00, 32'h12345678});
    exp_a.push_back({8'h01, 32'hDEADBEEF});
    fr = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_frame_a();
    check("ok_active_pre_csum", {31'd0, active_a}, 32'd0);
    check("ok_words_pre_csum", {16'd0, words_a}, 32'd2);
    send_a(8'h4C);
    check("ok_active", {31'd0, active_a}, 32'd1);
    check("ok_words", {16'd0, words_a}, 32'd2);
    check("ok_err", {29'd0, err_a, code_a}, 32'd0);
    tick(2);

    // DONE ignores a new frame; restart then reload a single word.
    fr = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA};
    send_frame_a();
    check("done_active_hold", {31'd0, active_a}, 32'd1);
    check("done_words_hold", {16'd0, words_a}, 32'd2);
    restart_pulse_a();
    check("restart_active", {31'd0, active_a}, 32'd0);
    check("restart_words_hold", {16'd0, words_a}, 32'd2);
    exp_a.push_back({8'h00, 32'h04030201});
    fr = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    send_frame_a();
    check("reload_active_pre", {31'd0, active_a}, 32'd0);
    send_a(8'h0A);
    check("reload_active", {31'd0, active_a}, 32'd1);
    check("reload_words", {16'd0, words_a}, 32'd1);

    // Bad checksum: both writes still happen, then CSUM error.
    restart_pulse_a();
    exp_a.push_back({8'h00, 32'h12345678});
    exp_a.push_back({8'h01, 32'hDEADBEEF});
    fr = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h49};
    send_frame_a();
    check("csum_err", {31'd0, err_a}, 32'd1);
    check("csum_code", {30'd0, code_a}, 32'd2);
    check("csum_active", {31'd0, active_a}, 32'd0);
    check("csum_words", {16'd0, words_a}, 32'd2);

    // Length zero and length 257 (> MAX_WORDS).
    restart_pulse_a();
    check("restart_err_clr", {29'd0, err_a, code_a}, 32'd0);
    fr = '{8'hA5, 8'h00, 8'h00};
    send_frame_a();
    check("len0_code", {29'd0, err_a, code_a}, {29'd0, 1'b1, 2'd1});
    check("len0_words", {16'd0, words_a}, 32'd0);
    restart_pulse_a();
    fr = '{8'hA5, 8'h01, 8'h01};
    send_frame_a();
    check("len257_code", {29'd0, err_a, code_a}, {29'd0, 1'b1, 2'd1});

    // Gap timeout after two payload bytes: error on the 16th idle clock.
    restart_pulse_a();
    fr = '{8'hA5, 8'h01, 8'h00, 8'h78, 8'h56};
    send_frame_a();
    tick(15);
    check("gap_15_no_err", {31'd0, err_a}, 32'd0);
    tick(1);
    check("gap_16_code", {29'd0, err_a, code_a}, {29'd0, 1'b1, 2'd3});
    check("gap_active", {31'd0, active_a}, 32'd0);

    // A magic byte coincident with restart is dropped; later bytes stay ignored.
    restart_a = 1'b1; dv_a = 1'b1; byte_a = 8'hA5;
    @(posedge clk); #1;
    restart_a = 1'b0; dv_a = 1'b0;
    check("drop_err_clr", {29'd0, err_a, code_a}, 32'd0);
    fr = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    send_frame_a();
    tick(2);
    check("drop_active", {31'd0, active_a}, 32'd0);
    check("drop_err", {31'd0, err_a}, 32'd0);

    // 16-bit instance, back-to-back bytes, three words (sum 0x165).
    exp_b.push_back({4'h0, 16'h2211});
    exp_b.push_back({4'h1, 16'h4433});
    exp_b.push_back({4'h2, 16'h6655});
    fr = '{8'hA5, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h65};
    send_frame_b();
    check("b_active", {31'd0, active_b}, 32'd1);
    check("b_words", {16'd0, words_b}, 32'd3);
    check("b_last_addr", {28'd0, addr_b}, 32'd2);

    // Reset in the middle of a word: no write, everything back to zero.
    restart_b = 1'b1;
    @(posedge clk); #1;
    restart_b = 1'b0;
    fr = '{8'hA5, 8'h01, 8'h00, 8'hAA};
    send_frame_b();
    rst = 1'b1; dv_b = 1'b1; byte_b = 8'hBB;
    @(posedge clk); #1;
    rst = 1'b0; dv_b = 1'b0;
    check("midrst_we_b", {31'd0, we_b}, 32'd0);
    check("midrst_addr_b", {28'd0, addr_b}, 32'd0);
    check("midrst_wdata_b", {16'd0, wdata_b}, 32'd0);
    check("midrst_status_b", {28'd0, active_b, err_b, code_b}, 32'd0);
    check("midrst_words_b", {16'd0, words_b}, 32'd0);
    tick(4);
    check("midrst_still_idle_b", {16'd0, words_b}, 32'd0);

    check("exp_a_drained", exp_a.size(), 32'd0);
    check("exp_b_drained", exp_b.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
